// File: rtl/blk_timing.sv
// blk_timing: video-timing front end for the block-accumulation engine.
// It registers the pixel stream and produces h_save/v_save block strobes,
// the block coordinates, and a sticky geometry-error flag.
module blk_timing #(
    parameter int unsigned HBLKS = 10,
    parameter int unsigned VBLKS = 10,
    parameter int unsigned BLK_W = 30,
    parameter int unsigned BLK_H = 30
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         vs_i,
    input  logic                         hs_i,
    input  logic                         de_i,
    input  logic [23:0]                  wd_i,
    output logic                         de_o,
    output logic                         hs_o,
    output logic                         vs_o,
    output logic [23:0]                  wd_o,
    output logic                         h_save_o,
    output logic                         v_save_o,
    output logic [$clog2(HBLKS+1)-1:0]   hblk_o,
    output logic [$clog2(VBLKS+1)-1:0]   vblk_o,
    output logic                         err_o
);

    localparam int unsigned HW = $clog2(HBLKS + 1);
    localparam int unsigned VW = $clog2(VBLKS + 1);
    localparam int unsigned PW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned LW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    typedef enum logic [0:0] {
        S_WAIT_VS = 1'b0,
        S_RUN     = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_vs;
    logic            r_hs;
    logic            r_de;
    logic [23:0]     r_wd;
    logic            r_de_o;
    logic            r_hsave;
    logic            r_vsave;
    logic [HW-1:0]   r_hblk_o;
    logic [VW-1:0]   r_vblk_o;
    logic            r_err;
    logic [PW-1:0]   r_px;
    logic [HW-1:0]   r_hblk;
    logic [LW-1:0]   r_ln;
    logic [VW-1:0]   r_vblk;

    logic            w_vs_rise;
    logic            w_de_fall;
    logic            w_run;
    logic            w_de_nxt;
    logic            w_hsave_nxt;
    logic            w_vsave_nxt;
    logic            w_err_nxt;
    logic [PW-1:0]   w_px_c;
    logic [HW-1:0]   w_hblk_c;
    logic [LW-1:0]   w_ln_c;
    logic [VW-1:0]   w_vblk_c;
    logic [PW-1:0]   w_px_nxt;
    logic [HW-1:0]   w_hblk_nxt;
    logic [LW-1:0]   w_ln_nxt;
    logic [VW-1:0]   w_vblk_nxt;

    // State register: wait for the first vsync, then track frames
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_WAIT_VS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and strobe logic; a vsync rise clears counters before the pixel is counted
    always_comb begin
        w_state_nxt = r_state;
        w_vs_rise   = vs_i & ~r_vs;
        w_de_fall   = ~de_i & r_de;
        w_err_nxt   = r_err;
        w_hsave_nxt = 1'b0;
        w_vsave_nxt = 1'b0;
        w_px_c      = r_px;
        w_hblk_c    = r_hblk;
        w_ln_c      = r_ln;
        w_vblk_c    = r_vblk;

        if (w_vs_rise) begin
            w_state_nxt = S_RUN;
            if ((r_state == S_RUN) && ((r_vblk != VW'(VBLKS)) || (r_ln != '0))) begin
                w_err_nxt = 1'b1;
            end
            w_px_c   = '0;
            w_hblk_c = '0;
            w_ln_c   = '0;
            w_vblk_c = '0;
        end

        w_run      = (r_state == S_RUN) | w_vs_rise;
        w_de_nxt   = w_run & de_i;
        w_px_nxt   = w_px_c;
        w_hblk_nxt = w_hblk_c;
        w_ln_nxt   = w_ln_c;
        w_vblk_nxt = w_vblk_c;

        if (w_run && de_i) begin
            if (w_hblk_c < HW'(HBLKS)) begin
                if (w_px_c == PW'(BLK_W - 1)) begin
                    w_hsave_nxt = 1'b1;
                    w_px_nxt    = '0;
                    w_hblk_nxt  = w_hblk_c + HW'(1);
                end else begin
                    w_px_nxt = w_px_c + PW'(1);
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (w_run && w_de_fall && !w_vs_rise) begin
            if ((w_hblk_c != HW'(HBLKS)) || (w_px_c != '0)) begin
                w_err_nxt = 1'b1;
            end
            w_px_nxt   = '0;
            w_hblk_nxt = '0;
            if (w_vblk_c < VW'(VBLKS)) begin
                if (w_ln_c == LW'(BLK_H - 1)) begin
                    w_vsave_nxt = 1'b1;
                    w_ln_nxt    = '0;
                    w_vblk_nxt  = w_vblk_c + VW'(1);
                end else begin
                    w_ln_nxt = w_ln_c + LW'(1);
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    // Datapath registers: pipelined video, strobes, coordinates and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs     <= 1'b0;
            r_hs     <= 1'b0;
            r_de     <= 1'b0;
            r_wd     <= '0;
            r_de_o   <= 1'b0;
            r_hsave  <= 1'b0;
            r_vsave  <= 1'b0;
            r_hblk_o <= '0;
            r_vblk_o <= '0;
            r_err    <= 1'b0;
            r_px     <= '0;
            r_hblk   <= '0;
            r_ln     <= '0;
            r_vblk   <= '0;
        end else begin
            r_vs     <= vs_i;
            r_hs     <= hs_i;
            r_de     <= de_i;
            r_wd     <= wd_i;
            r_de_o   <= w_de_nxt;
            r_hsave  <= w_hsave_nxt;
            r_vsave  <= w_vsave_nxt;
            r_hblk_o <= w_hblk_c;
            r_vblk_o <= w_vblk_c;
            r_err    <= w_err_nxt;
            r_px     <= w_px_nxt;
            r_hblk   <= w_hblk_nxt;
            r_ln     <= w_ln_nxt;
            r_vblk   <= w_vblk_nxt;
        end
    end

    assign de_o     = r_de_o;
    assign hs_o     = r_hs;
    assign vs_o     = r_vs;
    assign wd_o     = r_wd;
    assign h_save_o = r_hsave;
    assign v_save_o = r_vsave;
    assign hblk_o   = r_hblk_o;
    assign vblk_o   = r_vblk_o;
    assign err_o    = r_err;

endmodule

// File: tb/tb_blk_timing.sv
// tb_blk_timing: line-level table of directed scenarios for blk_timing
// with small geometry (2x2 blocks of 3x2 pixels), plus a mid-line reset sequence.
module tb_blk_timing;

    localparam int unsigned HBLKS = 2;
    localparam int unsigned VBLKS = 2;
    localparam int unsigned BLK_W = 3;
    localparam int unsigned BLK_H = 2;
    localparam int unsigned NLINES = 25;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        vs_i;
    logic        hs_i;
    logic        de_i;
    logic [23:0] wd_i;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;
    logic [23:0] wd_o;
    logic        h_save_o;
    logic        v_save_o;
    logic [1:0]  hblk_o;
    logic [1:0]  vblk_o;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_id = 0;

    // One record per video line: optional reset / vsync before it, pixel count, expected results
    typedef struct {
        bit         rst;
        bit         vs;
        bit         exp_de;
        int         npix;
        logic [7:0] hmask;
        bit         vsave;
        int         vblk;
        bit         err;
    } line_t;

    line_t tbl [NLINES];

    blk_timing #(
        .HBLKS(HBLKS), .VBLKS(VBLKS), .BLK_W(BLK_W), .BLK_H(BLK_H)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .vs_i     (vs_i),
        .hs_i     (hs_i),
        .de_i     (de_i),
        .wd_i     (wd_i),
        .de_o     (de_o),
        .hs_o     (hs_o),
        .vs_o     (vs_o),
        .wd_o     (wd_o),
        .h_save_o (h_save_o),
        .v_save_o (v_save_o),
        .hblk_o   (hblk_o),
        .vblk_o   (vblk_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic line_t mk(input bit rst, input bit vs, input bit ede, input int n,
                                 input logic [7:0] m, input bit vsv, input int vb, input bit e);
        line_t r;
        r.rst = rst; r.vs = vs; r.exp_de = ede; r.npix = n;
        r.hmask = m; r.vsave = vsv; r.vblk = vb; r.err = e;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s (line %0d): got %0d, expected %0d", nm, cur_id, act, exp_v);
        end
    endtask

    task automatic check_zero();
        chk("rst de_o", int'(de_o), 0);
        chk("rst hs_o", int'(hs_o), 0);
        chk("rst vs_o", int'(vs_o), 0);
        chk("rst wd_o", int'(wd_o), 0);
        chk("rst h_save_o", int'(h_save_o), 0);
        chk("rst v_save_o", int'(v_save_o), 0);
        chk("rst hblk_o", int'(hblk_o), 0);
        chk("rst vblk_o", int'(vblk_o), 0);
        chk("rst err_o", int'(err_o), 0);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1; de_i = 1'b0;
        step();
        chk("vs_o", int'(vs_o), 1);
        chk("de_o during vs", int'(de_o), 0);
        vs_i = 1'b0;
        step();
        step();
    endtask

    task automatic run_line(input line_t r);
        logic [23:0] px;
        int          col;
        if (r.rst) begin
            rst_i = 1'b1; de_i = 1'b0; vs_i = 1'b0; hs_i = 1'b0; wd_i = 24'h0;
            step();
            check_zero();
            rst_i = 1'b0;
        end
        if (r.vs) vs_pulse();
        for (int p = 0; p < r.npix; p++) begin
            px   = 24'($urandom);
            de_i = 1'b1;
            wd_i = px;
            step();
            chk("de_o", int'(de_o), int'(r.exp_de));
            chk("wd_o", int'(wd_o), int'(px));
            chk("h_save_o", int'(h_save_o), int'(r.hmask[p]));
            chk("v_save_o in line", int'(v_save_o), 0);
            if (r.exp_de) begin
                col = p / int'(BLK_W);
                if (col > int'(HBLKS)) col = int'(HBLKS);
                chk("hblk_o", int'(hblk_o), col);
                if (p == 0) chk("vblk_o", int'(vblk_o), r.vblk);
            end
        end
        de_i = 1'b0;
        step();
        chk("de_o after line", int'(de_o), 0);
        chk("h_save_o after line", int'(h_save_o), 0);
        chk("v_save_o", int'(v_save_o), int'(r.vsave));
        hs_i = 1'b1;
        step();
        chk("hs_o", int'(hs_o), 1);
        chk("v_save_o one cycle", int'(v_save_o), 0);
        hs_i = 1'b0;
        step();
        chk("err_o", int'(err_o), int'(r.err));
    endtask

    initial begin
        // pre-sync traffic after reset
        tbl[0]  = mk(1, 0, 0, 6, 8'h00, 0, 0, 0);
        // clean frame
        tbl[1]  = mk(0, 1, 1, 6, 8'h24, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 6, 8'h24, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 6, 8'h24, 0, 1, 0);
        tbl[4]  = mk(0, 0, 1, 6, 8'h24, 1, 1, 0);
        // frame with a 5-pixel short line
        tbl[5]  = mk(0, 1, 1, 6, 8'h24, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 5, 8'h04, 1, 0, 1);
        tbl[7]  = mk(0, 0, 1, 6, 8'h24, 0, 1, 1);
        tbl[8]  = mk(0, 0, 1, 6, 8'h24, 1, 1, 1);
        // clean frame, error stays sticky
        tbl[9]  = mk(0, 1, 1, 6, 8'h24, 0, 0, 1);
        tbl[10] = mk(0, 0, 1, 6, 8'h24, 1, 0, 1);
        tbl[11] = mk(0, 0, 1, 6, 8'h24, 0, 1, 1);
        tbl[12] = mk(0, 0, 1, 6, 8'h24, 1, 1, 1);
        // reset, frame starting with a 7-pixel long line
        tbl[13] = mk(1, 1, 1, 7, 8'h24, 0, 0, 1);
        tbl[14] = mk(0, 0, 1, 6, 8'h24, 1, 0, 1);
        tbl[15] = mk(0, 0, 1, 6, 8'h24, 0, 1, 1);
        tbl[16] = mk(0, 0, 1, 6, 8'h24, 1, 1, 1);
        // reset, 3 lines then early vsync, then a full frame
        tbl[17] = mk(1, 1, 1, 6, 8'h24, 0, 0, 0);
        tbl[18] = mk(0, 0, 1, 6, 8'h24, 1, 0, 0);
        tbl[19] = mk(0, 0, 1, 6, 8'h24, 0, 1, 0);
        tbl[20] = mk(0, 1, 1, 6, 8'h24, 0, 0, 1);
        tbl[21] = mk(0, 0, 1, 6, 8'h24, 1, 0, 1);
        tbl[22] = mk(0, 0, 1, 6, 8'h24, 0, 1, 1);
        tbl[23] = mk(0, 0, 1, 6, 8'h24, 1, 1, 1);
        // excess fifth line: no v_save, block row saturated
        tbl[24] = mk(0, 0, 1, 6, 8'h24, 0, 2, 1);

        rst_i = 1'b1; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; wd_i = 24'h0;
        step();
        step();

        for (int i = 0; i < int'(NLINES); i++) begin
            cur_id = i;
            run_line(tbl[i]);
        end

        // mid-line reset: outputs clear at once, nothing happens until the next vsync
        cur_id = 100;
        vs_pulse();
        for (int p = 0; p < 2; p++) begin
            de_i = 1'b1;
            wd_i = 24'h123456;
            step();
            chk("mid de_o", int'(de_o), 1);
        end
        rst_i = 1'b1;
        wd_i  = 24'hABCDEF;
        step();
        check_zero();
        rst_i  = 1'b0;
        cur_id = 101;
        run_line(mk(0, 0, 0, 4, 8'h00, 0, 0, 0));
        cur_id = 102;
        run_line(mk(0, 1, 1, 6, 8'h24, 0, 0, 0));
        cur_id = 103;
        run_line(mk(0, 0, 1, 6, 8'h24, 1, 0, 0));
        cur_id = 104;
        run_line(mk(0, 0, 1, 6, 8'h24, 0, 1, 0));
        cur_id = 105;
        run_line(mk(0, 0, 1, 6, 8'h24, 1, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blk_timing.md
Name: blk_timing

Overview:
- Video-timing front end that drives the block-accumulation engine's control interface.
- Registers the incoming RGB pixel stream and emits the h_save/v_save strobes that the block buffer consumes.
  - h_save marks the last pixel of each horizontal block.
  - v_save marks the end of each block row.
- Tracks block coordinates and flags geometry violations so downstream block flags are never built from misaligned frames.

Parameters:
HBLKS, 10, blocks per line
VBLKS, 10, block rows per frame
BLK_W, 30, pixels per block horizontally
BLK_H, 30, lines per block vertically

Ports:
clk_i  in  1  pixel clock, only clock
rst_i  in  1  synchronous, active-high reset
vs_i  in  1  vsync, active-high; rising edge = frame start
hs_i  in  1  hsync, active-high; passed through only
de_i  in  1  data enable
wd_i  in  24  pixel {R,G,B}
de_o  out  1  registered de, gated by state
hs_o  out  1  registered hs_i
vs_o  out  1  registered vs_i
wd_o  out  24  registered wd_i
h_save_o  out  1  last pixel of a horizontal block, coincident with de_o
v_save_o  out  1  block-row boundary pulse
hblk_o  out  $clog2(HBLKS+1)  block column of current de_o pixel
vblk_o  out  $clog2(VBLKS+1)  block row of current line
err_o  out  1  sticky geometry error

Behaviour:
- Reset: every output 0, all counters 0, FSM=WAIT_VS. Reset has priority over every other event, including mid-line.
- Latency: 1 cycle from inputs to de_o/wd_o/hs_o/vs_o. h_save_o and v_save_o are registered and aligned to de_o.
- Edge detect: vs_r, de_r are internal previous-cycle copies.
  - vs rise = vs_i & ~vs_r.
  - de fall = ~de_i & de_r.
- FSM WAIT_VS:
  - de_o forced 0; no strobes.
  - hs_o/vs_o/wd_o still pass through.
  - On vs rise: clear px_cnt, hblk, ln_cnt, vblk; go RUN.
- FSM RUN:
  - de_o = de_i delayed.
  - On vs rise: if vblk != VBLKS or ln_cnt != 0, set err_o (incomplete frame). Clear all counters; stay RUN.
- Per active pixel (RUN, de_i=1):
  - If hblk < HBLKS:
    - h_save_o=1 when px_cnt==BLK_W-1; then px_cnt wraps to 0 and hblk increments.
    - Otherwise px_cnt increments.
  - If hblk == HBLKS (excess pixels): no h_save; set err_o.
- On de fall (RUN):
  - If hblk != HBLKS, or px_cnt != 0: set err_o (short line).
  - Clear px_cnt and hblk.
  - If vblk < VBLKS:
    - If ln_cnt == BLK_H-1: assert v_save_o for exactly one cycle, on the cycle after the last de_o pixel. Set ln_cnt=0 and vblk+=1.
    - Otherwise ln_cnt+=1.
  - If vblk == VBLKS: excess line; no v_save; set err_o.
- Strobe separation: v_save_o never coincides with h_save_o. It follows the last h_save_o of the line by exactly one cycle.
- A 1-pixel-gap de glitch counts as a line end.
- hblk_o/vblk_o are registered with the pixel; values saturate at HBLKS/VBLKS.
- vs rise coinciding with de=1: the vs handling (counter clear) takes priority; the pixel counts as pixel 0 of the new frame.
- err_o clears only on rst_i.
- Width rule: counters use $clog2(max+1) bits; no wrap beyond the saturation values.

Test Plan:
Parameters HBLKS=2, VBLKS=2, BLK_W=3, BLK_H=2 for all scenarios.
- Reset then clean frame: vs pulse, then 4 lines of 6 de pixels each -> h_save_o high on pixel indices 2 and 5 of every line (8 per frame pairs); v_save_o pulses once after lines 2 and 4, each 1 cycle after the last pixel; err_o stays 0.
- Pre-sync traffic: de pixels before the first vs rise -> de_o=0, no strobes; the following frame behaves as in the clean-frame case.
- Short line: one 5-pixel line -> a single h_save (index 2); err_o=1 after the line and stays 1 through later clean frames.
- Long line: 7 pixels -> h_save at indices 2 and 5 only; hblk_o saturates at 2; err_o=1.
- Early vsync: vs rise after 3 lines -> err_o=1; counters clear; the next frame produces correct strobes.
- Mid-line rst_i for 1 cycle -> all outputs 0 the next cycle; no strobes until the next vs rise.
